// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker and its xorshift64 generator.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int IDX_W = 16;
    localparam logic [IDX_W-1:0] IDX_NONE = 16'hFFFF;
    localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

    // One xorshift64 advance: shift-xor by 13 left, 7 right, 17 left, in that order.
    function automatic logic [63:0] xorshift64_step(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

endpackage

// File: rtl/xorshift64_gen.sv
// 64-bit xorshift pseudo-random generator; load takes priority over advance.
module xorshift64_gen
    import gate_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        adv,
    output logic [63:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DEFAULT_SEED;
        end else if (load) begin
            state <= seed;
        end else if (adv) begin
            state <= xorshift64_step(state);
        end
    end

endmodule

// File: rtl/gate_vec_checker.sv
// Drives pseudo-random vectors into an and2 gate DUT and checks its results after LAT cycles,
// reporting pass/fail, a saturating mismatch count and the first failing vector index.
module gate_vec_checker
    import gate_chk_pkg::*;
#(
    parameter int          WIDTH    = 64,
    parameter int          NUM_VECS = 256,
    parameter int          LAT      = 0,
    parameter logic [63:0] SEED     = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH-1:0] dut_in1,
    output logic [WIDTH-1:0] dut_in2,
    output logic [WIDTH-1:0] dut_in3,
    input  logic [WIDTH-1:0] dut_out
);

    chk_state_t       state;
    logic [63:0]      gen_state;
    logic [63:0]      swapped;
    logic [IDX_W-1:0] vec_idx;
    logic [1:0]       drain_cnt;
    logic             load;
    logic             running;
    logic             last_vec;
    logic             enter_done;
    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_exp;
    logic [IDX_W-1:0] cmp_idx;
    logic             mismatch;

    assign load     = (state == IDLE) && start;
    assign running  = (state == RUN);
    assign last_vec = (vec_idx == 16'(NUM_VECS - 1));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    // The edge that closes the final compare cycle, i.e. the one that moves into DONE.
    assign enter_done = (LAT == 0) ? (running && last_vec)
                                   : ((state == DRAIN) && (drain_cnt == 2'(LAT - 1)));

    xorshift64_gen u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .seed  (SEED),
        .adv   (running),
        .state (gen_state)
    );

    assign swapped = {gen_state[31:0], gen_state[63:32]};
    assign dut_in1 = running ? gen_state[WIDTH-1:0]  : '0;
    assign dut_in2 = running ? swapped[WIDTH-1:0]    : '0;
    assign dut_in3 = running ? ~gen_state[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        vec_idx <= '0;
                    end
                end
                RUN: begin
                    vec_idx <= vec_idx + 16'd1;
                    if (last_vec) begin
                        state     <= (LAT == 0) ? DONE : DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (enter_done) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Expected value, valid and index travel together so the compare lines up with the DUT latency.
    generate
        if (LAT == 0) begin : g_wire
            assign cmp_vld = running;
            assign cmp_exp = dut_in1 & dut_in2;
            assign cmp_idx = vec_idx;
        end else begin : g_pipe
            logic [LAT-1:0]   pipe_vld;
            logic [WIDTH-1:0] pipe_exp [LAT];
            logic [IDX_W-1:0] pipe_idx [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        pipe_exp[i] <= '0;
                        pipe_idx[i] <= '0;
                    end
                end else begin
                    pipe_vld[0] <= running;
                    pipe_exp[0] <= dut_in1 & dut_in2;
                    pipe_idx[0] <= vec_idx;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1];
                        pipe_exp[i] <= pipe_exp[i-1];
                        pipe_idx[i] <= pipe_idx[i-1];
                    end
                end
            end

            assign cmp_vld = pipe_vld[LAT-1];
            assign cmp_exp = pipe_exp[LAT-1];
            assign cmp_idx = pipe_idx[LAT-1];
        end
    endgenerate

    assign mismatch = cmp_vld && (dut_out != cmp_exp);

    // pass must include a mismatch found in the very last compare cycle, hence the !mismatch term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count     <= '0;
            first_err_idx <= IDX_NONE;
            pass          <= 1'b0;
        end else if (load) begin
            err_count     <= '0;
            first_err_idx <= IDX_NONE;
            pass          <= 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'd0) begin
                    first_err_idx <= cmp_idx;
                end
            end
            if (enter_done) begin
                pass <= (err_count == 16'd0) && !mismatch;
            end
        end
    end

endmodule

// File: doc/gate_vec_checker.md
# gate_vec_checker

Self-checking hardware stimulus and response block for the gate test benches. It drives pseudo-random vectors into a gate DUT and checks the DUT results in hardware, so no external C-TB is needed to drive vectors or compare results. The block issues one vector per cycle from a xorshift64 generator and computes the expected and2 result internally. It compares each expected result against the DUT output after a configurable DUT latency, then reports pass/fail, the mismatch count and the index of the first failing vector.

## Interface
- WIDTH, 64: DUT data width, 1..64; generator is always 64 bits, and outputs are its low WIDTH bits.
- NUM_VECS, 256: vectors per run, 1..65535.
- LAT, 0: DUT latency in cycles, 0..3; 0 means a combinational DUT.
- SEED, 64'h0000_0000_0000_0001: generator seed, nonzero.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin run; honoured only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high iff the last completed run had zero mismatches.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_idx  out  16  vector index of the first mismatch; 16'hFFFF if none.
- dut_in1, dut_in2, dut_in3  out  WIDTH  stimulus to the DUT.
- dut_out  in  WIDTH  DUT result.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start.
- RUN → DRAIN after vector NUM_VECS-1 is issued. If LAT=0, RUN → DONE directly.
- DRAIN → DONE after LAT cycles.
- DONE → IDLE unconditionally after one cycle.
- Generator: state s is loaded with SEED on start. Each RUN cycle presents s, then advances s with three steps in order:
  - s ^= s<<13
  - s ^= s>>7
  - s ^= s<<17
- Stimulus derived from s:
  - dut_in1 = s[WIDTH-1:0].
  - dut_in2 = {s[31:0], s[63:32]}[WIDTH-1:0].
  - dut_in3 = ~s[WIDTH-1:0].
- All dut_in* are 0 outside RUN.
- Expected value = dut_in1 & dut_in2. It travels with a valid bit and its 16-bit vector index through a LAT-deep shift pipe (wire-through when LAT=0).
- Compare: when the pipe output is valid, a mismatch is dut_out != expected (all WIDTH bits).
- On each mismatch, err_count increments, saturating at 16'hFFFF.
- first_err_idx captures the index on the first mismatch only.
- start in IDLE clears err_count to 0, sets first_err_idx to 16'hFFFF and clears pass.
- pass is set in DONE if err_count == 0. Results hold until the next start.
- start while busy or in DONE is ignored.

## Timing
- Reset values: state IDLE, busy 0, done 0, pass 0, err_count 0, first_err_idx 16'hFFFF, dut_in* 0, pipe valids 0.
- With start sampled high at edge T:
  - vector k is driven during cycle T+1+k;
  - its compare happens in cycle T+1+k+LAT;
  - busy is high for cycles T+1 .. T+NUM_VECS+LAT;
  - done and pass update in cycle T+NUM_VECS+LAT+1.
- Counters and first_err_idx update at the edge that closes the compare cycle.
- rst asserted mid-run: every output returns to its reset value immediately, and the partial run is discarded.
- Saturation: err_count holds at 16'hFFFF. pass stays 0.

## Structure
- Package gate_chk_pkg holds:
  - state enum type chk_state_t;
  - IDX_W = 16;
  - IDX_NONE = 16'hFFFF;
  - DEFAULT_SEED.
- Sub-module xorshift64_gen (clk, rst, load, seed, adv, state) holds the generator. The top contains the FSM, the latency pipe and the counters.

## Test plan
- SEED=1, WIDTH=64: dut_in1 for vector 0 is 64'h1 and for vector 1 is 64'h4082_2041. dut_in2 for vector 0 is 64'h0000_0001_0000_0000.
- Correct combinational and2 DUT, NUM_VECS=16, LAT=0, start at T: busy for T+1..T+16, done at T+17, pass=1, err_count=0, first_err_idx=16'hFFFF.
- Same DUT with output bit 0 inverted only while dut_in1 equals the vector-3 value: err_count=1, first_err_idx=3, pass=0.
- LAT=2 with and2 plus a 2-stage register DUT: pass=1, done at T+NUM_VECS+3. Same DUT with LAT=1: err_count>0, pass=0.
- start held high through an entire run: exactly one run occurs and one done pulse. A second start pulse issued while busy has no effect.
- rst asserted at vector 5 of a run: all outputs are at reset values in the same cycle. A following start completes a clean run with pass=1.
